// File: rtl/counter_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// counter_seq_ctrl_if
// Groups the button ticks, counter feedback and counter control lines that
// run between the debouncers/counter and the sequencing controller.
//
// Signals:
//   run_tick, dir_tick, clr_tick : one-cycle debounced button pulses
//   q_in[7:0]                    : current counter value (feedback)
//   cnt_en                       : one-cycle count-enable pulse to counter
//   cnt_up                       : count direction, 1 = up, 0 = down
//   cnt_clr                      : one-cycle synchronous clear to counter
//   state[1:0]                   : 00 IDLE, 01 RUN, 10 PAUSE, 11 HALT
//   done                         : high while halted at the terminal value
//
// Modports:
//   master : button/counter side (drives ticks and q_in)
//   slave  : controller side (drives counter controls and status)
// -----------------------------------------------------------------------------
interface counter_seq_ctrl_if;
    logic       run_tick;
    logic       dir_tick;
    logic       clr_tick;
    logic [7:0] q_in;
    logic       cnt_en;
    logic       cnt_up;
    logic       cnt_clr;
    logic [1:0] state;
    logic       done;

    modport master (
        output run_tick, dir_tick, clr_tick, q_in,
        input  cnt_en, cnt_up, cnt_clr, state, done
    );

    modport slave (
        input  run_tick, dir_tick, clr_tick, q_in,
        output cnt_en, cnt_up, cnt_clr, state, done
    );
endinterface

// File: rtl/counter_seq_ctrl.sv
// -----------------------------------------------------------------------------
// counter_seq_ctrl
// Sequencing controller for the 8-bit counter datapath. Turns debounced
// run/pause, direction and clear ticks into registered enable/direction/clear
// controls, paces counting with an internal prescaler and stops at a
// programmable terminal value.
//
// Parameters:
//   DIV     : clk cycles between count-enable pulses while running (>= 2)
//   MAX_VAL : terminal value when counting up
//   MIN_VAL : terminal value when counting down
//
// Ports:
//   clk   : system clock, all logic on the rising edge
//   reset : synchronous, active-low reset
//   bus   : counter_seq_ctrl_if.slave (ticks and q_in in; controls out)
//
// Build option:
//   COUNTER_SEQ_CTRL_AUTORELOAD_EN - when defined, reaching the terminal value
//   in RUN issues a cnt_clr pulse plus a one-cycle done pulse and keeps
//   running instead of entering HALT.
// -----------------------------------------------------------------------------
module counter_seq_ctrl #(
    parameter int         DIV     = 4,
    parameter logic [7:0] MAX_VAL = 8'hFF,
    parameter logic [7:0] MIN_VAL = 8'h00
) (
    input logic               clk,
    input logic               reset,
    counter_seq_ctrl_if.slave bus
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        HALT  = 2'b11
    } state_t;

    state_t        state_r,   state_nx_s;
    logic [PW-1:0] pcnt_r,    pcnt_nx_s;
    logic          cnt_en_r,  cnt_en_nx_s;
    logic          cnt_up_r,  cnt_up_nx_s;
    logic          cnt_clr_r, cnt_clr_nx_s;
    logic          done_r,    done_nx_s;

    // Terminal test against the direction that will be in force after this
    // cycle, so a direction tick landing on an enable event is honoured.
    function automatic logic is_terminal(input logic up, input logic [7:0] q);
        logic term;
        if (up) begin
            term = (q == MAX_VAL);
        end else begin
            term = (q == MIN_VAL);
        end
        return term;
    endfunction

    // State, prescaler and registered output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= IDLE;
            pcnt_r    <= '0;
            cnt_en_r  <= 1'b0;
            cnt_up_r  <= 1'b1;
            cnt_clr_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            pcnt_r    <= pcnt_nx_s;
            cnt_en_r  <= cnt_en_nx_s;
            cnt_up_r  <= cnt_up_nx_s;
            cnt_clr_r <= cnt_clr_nx_s;
            done_r    <= done_nx_s;
        end
    end

    // Next-state, prescaler and output decode; clear beats run beats direction.
    always_comb begin
        state_nx_s   = state_r;
        pcnt_nx_s    = pcnt_r;
        cnt_en_nx_s  = 1'b0;
        cnt_up_nx_s  = cnt_up_r;
        cnt_clr_nx_s = 1'b0;
        done_nx_s    = 1'b0;

        if (bus.clr_tick) begin
            cnt_clr_nx_s = 1'b1;
            state_nx_s   = IDLE;
            pcnt_nx_s    = '0;
        end else begin
            if (bus.dir_tick && (state_r != HALT)) begin
                cnt_up_nx_s = ~cnt_up_r;
            end else begin
                cnt_up_nx_s = cnt_up_r;
            end

            case (state_r)
                IDLE: begin
                    if (bus.run_tick) begin
                        state_nx_s = RUN;
                        pcnt_nx_s  = '0;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                RUN: begin
                    if (bus.run_tick) begin
                        // Pause wins over a coincident enable event; pcnt holds.
                        state_nx_s = PAUSE;
                    end else if (pcnt_r == PCNT_LAST) begin
                        pcnt_nx_s = '0;
                        if (is_terminal(cnt_up_nx_s, bus.q_in)) begin
`ifdef COUNTER_SEQ_CTRL_AUTORELOAD_EN
                            cnt_clr_nx_s = 1'b1;
                            done_nx_s    = 1'b1;
                            state_nx_s   = RUN;
`else
                            state_nx_s   = HALT;
                            done_nx_s    = 1'b1;
`endif
                        end else begin
                            cnt_en_nx_s = 1'b1;
                        end
                    end else begin
                        pcnt_nx_s = pcnt_r + PW'(1);
                    end
                end
                PAUSE: begin
                    if (bus.run_tick) begin
                        state_nx_s = RUN;
                        pcnt_nx_s  = '0;
                    end else begin
                        state_nx_s = PAUSE;
                    end
                end
                HALT: begin
                    // Only a clear leaves HALT; run and direction ticks are dropped.
                    state_nx_s = HALT;
                    done_nx_s  = 1'b1;
                end
                default: begin
                    state_nx_s = IDLE;
                    pcnt_nx_s  = '0;
                end
            endcase
        end
    end

    assign bus.cnt_en  = cnt_en_r;
    assign bus.cnt_up  = cnt_up_r;
    assign bus.cnt_clr = cnt_clr_r;
    assign bus.state   = state_r;
    assign bus.done    = done_r;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_seq_ctrl
// Directed self-checking bench for counter_seq_ctrl with DIV=4, MAX_VAL=5,
// MIN_VAL=0 and an attached 8-bit counter model feeding q_in. Expected
// enable pulses (cycle, counter value, direction) are queued when stimulus is
// applied and popped when the controller emits cnt_en.
// -----------------------------------------------------------------------------
module tb_counter_seq_ctrl;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic [7:0] q_model = 8'h00;

    counter_seq_ctrl_if bus ();

    counter_seq_ctrl #(
        .DIV     (4),
        .MAX_VAL (8'h05),
        .MIN_VAL (8'h00)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Counter datapath model driven by the controller outputs.
    always @(posedge clk) begin
        if (bus.cnt_clr) begin
            q_model <= 8'h00;
        end else if (bus.cnt_en) begin
            q_model <= bus.cnt_up ? q_model + 8'd1 : q_model - 8'd1;
        end
    end

    assign bus.q_in = q_model;

    typedef struct {
        int         cyc;
        logic [7:0] q;
        logic       up;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int c, input logic [7:0] q, input logic up);
        exp_t e;
        e.cyc = c;
        e.q   = q;
        e.up  = up;
        sb.push_back(e);
    endtask

    // One clock; outputs sampled 1 time unit after the edge.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        chk("en_clr_exclusive", {31'd0, bus.cnt_en & bus.cnt_clr}, 32'd0);
        if (bus.cnt_en) begin
            if (sb.size() == 0) begin
                chk("unexpected_cnt_en_cycle", cyc, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("cnt_en_cycle", cyc, e.cyc);
                chk("cnt_en_q_in", {24'd0, bus.q_in}, {24'd0, e.q});
                chk("cnt_en_dir", {31'd0, bus.cnt_up}, {31'd0, e.up});
            end
        end
    endtask

    task automatic run_to(input int n);
        for (int k = 0; k < 200; k++) begin
            if (cyc < n) step();
        end
    endtask

    task automatic tick(input logic r, input logic d, input logic c);
        bus.run_tick = r;
        bus.dir_tick = d;
        bus.clr_tick = c;
        step();
        bus.run_tick = 1'b0;
        bus.dir_tick = 1'b0;
        bus.clr_tick = 1'b0;
    endtask

    int e0, e1, e2, e3, e4;

    initial begin
        bus.run_tick = 1'b0;
        bus.dir_tick = 1'b0;
        bus.clr_tick = 1'b0;

        // Reset values
        reset = 1'b0;
        step();
        step();
        chk("rst_state", {30'd0, bus.state}, 32'd0);
        chk("rst_cnt_en", {31'd0, bus.cnt_en}, 32'd0);
        chk("rst_cnt_up", {31'd0, bus.cnt_up}, 32'd1);
        chk("rst_cnt_clr", {31'd0, bus.cnt_clr}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        reset = 1'b1;

        // Run up to MAX_VAL and halt
        tick(1'b1, 1'b0, 1'b0);
        e0 = cyc;
        chk("run_state", {30'd0, bus.state}, 32'd1);
        for (int i = 0; i < 5; i++) push(e0 + 4 * (i + 1), 8'(i), 1'b1);
        run_to(e0 + 24);
        chk("halt_state", {30'd0, bus.state}, 32'd3);
        chk("halt_done", {31'd0, bus.done}, 32'd1);
        chk("halt_no_en", {31'd0, bus.cnt_en}, 32'd0);
        chk("halt_q", {24'd0, bus.q_in}, 32'd5);
        chk("halt_pulses_all_seen", sb.size(), 32'd0);
        run_to(e0 + 27);
        chk("halt_hold", {30'd0, bus.state}, 32'd3);

        // HALT ignores dir and run; clear leaves
        tick(1'b0, 1'b1, 1'b0);
        chk("halt_dir_ignored", {31'd0, bus.cnt_up}, 32'd1);
        tick(1'b1, 1'b0, 1'b0);
        chk("halt_run_ignored", {30'd0, bus.state}, 32'd3);
        tick(1'b0, 1'b0, 1'b1);
        chk("clr_pulse", {31'd0, bus.cnt_clr}, 32'd1);
        chk("clr_state", {30'd0, bus.state}, 32'd0);
        chk("clr_done", {31'd0, bus.done}, 32'd0);
        step();
        chk("clr_q_zero", {24'd0, bus.q_in}, 32'd0);
        chk("clr_one_cycle", {31'd0, bus.cnt_clr}, 32'd0);

        // Pause coinciding with an enable event, then resume
        tick(1'b1, 1'b0, 1'b0);
        e1 = cyc;
        push(e1 + 4, 8'd0, 1'b1);
        push(e1 + 8, 8'd1, 1'b1);
        run_to(e1 + 11);
        tick(1'b1, 1'b0, 1'b0);
        chk("pause_state", {30'd0, bus.state}, 32'd2);
        chk("pause_wins_no_en", {31'd0, bus.cnt_en}, 32'd0);
        run_to(e1 + 30);
        chk("pause_q_hold", {24'd0, bus.q_in}, 32'd2);
        chk("pause_state_hold", {30'd0, bus.state}, 32'd2);
        chk("pause_pulses_all_seen", sb.size(), 32'd0);
        tick(1'b1, 1'b0, 1'b0);
        e2 = cyc;
        chk("resume_state", {30'd0, bus.state}, 32'd1);
        push(e2 + 4, 8'd2, 1'b1);
        run_to(e2 + 5);
        chk("resume_q", {24'd0, bus.q_in}, 32'd3);

        // Reverse at 3 and count down to MIN_VAL
        tick(1'b0, 1'b1, 1'b0);
        chk("dir_toggle", {31'd0, bus.cnt_up}, 32'd0);
        push(e2 + 8, 8'd3, 1'b0);
        push(e2 + 12, 8'd2, 1'b0);
        push(e2 + 16, 8'd1, 1'b0);
        run_to(e2 + 20);
        chk("min_halt_state", {30'd0, bus.state}, 32'd3);
        chk("min_halt_done", {31'd0, bus.done}, 32'd1);
        chk("min_halt_q", {24'd0, bus.q_in}, 32'd0);
        chk("down_pulses_all_seen", sb.size(), 32'd0);

        // Simultaneous ticks
        tick(1'b0, 1'b0, 1'b1);
        chk("clr_keeps_dir", {31'd0, bus.cnt_up}, 32'd0);
        tick(1'b1, 1'b1, 1'b0);
        e3 = cyc;
        chk("run_dir_state", {30'd0, bus.state}, 32'd1);
        chk("run_dir_up", {31'd0, bus.cnt_up}, 32'd1);
        step();
        tick(1'b1, 1'b1, 1'b1);
        chk("all_ticks_state", {30'd0, bus.state}, 32'd0);
        chk("all_ticks_dir", {31'd0, bus.cnt_up}, 32'd1);
        chk("all_ticks_clr", {31'd0, bus.cnt_clr}, 32'd1);
        run_to(e3 + 8);
        chk("all_ticks_idle", {30'd0, bus.state}, 32'd0);

        // Reset landing on an enable event
        tick(1'b1, 1'b0, 1'b0);
        e4 = cyc;
        push(e4 + 4, 8'd0, 1'b1);
        run_to(e4 + 7);
        reset = 1'b0;
        step();
        chk("mid_rst_state", {30'd0, bus.state}, 32'd0);
        chk("mid_rst_no_en", {31'd0, bus.cnt_en}, 32'd0);
        chk("mid_rst_up", {31'd0, bus.cnt_up}, 32'd1);
        chk("mid_rst_clr", {31'd0, bus.cnt_clr}, 32'd0);
        chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
        reset = 1'b1;
        run_to(e4 + 16);
        chk("post_rst_idle", {30'd0, bus.state}, 32'd0);
        chk("rst_pulses_all_seen", sb.size(), 32'd0);

`ifdef COUNTER_SEQ_CTRL_AUTORELOAD_EN
        // Terminal reload instead of halt
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        e0 = cyc;
        for (int i = 0; i < 5; i++) push(e0 + 4 * (i + 1), 8'(i), 1'b1);
        run_to(e0 + 24);
        chk("ar_clr", {31'd0, bus.cnt_clr}, 32'd1);
        chk("ar_done", {31'd0, bus.done}, 32'd1);
        chk("ar_state", {30'd0, bus.state}, 32'd1);
        step();
        chk("ar_done_pulse", {31'd0, bus.done}, 32'd0);
        chk("ar_q_zero", {24'd0, bus.q_in}, 32'd0);
        chk("ar_pulses_all_seen", sb.size(), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Sequencing controller for the 8-bit counter datapath. It takes single-cycle debounced button ticks (run/pause, direction, clear) and drives the counter's enable, direction and clear controls.
- It paces counting through an internal prescaler and stops at a programmable terminal value.
- It sits between the button debouncers and the counter inside the top level. The counter value is fed back on q_in for terminal detection.

Parameters:
- DIV, 4: number of clk cycles between count-enable pulses while running (≥2).
- MAX_VAL, 8'hFF: terminal value when counting up.
- MIN_VAL, 8'h00: terminal value when counting down.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- run_tick  input  1  one-cycle pulse, toggles run/pause
- dir_tick  input  1  one-cycle pulse, toggles count direction
- clr_tick  input  1  one-cycle pulse, clears counter and returns to IDLE
- q_in  input  8  current counter value (feedback from counter)
- cnt_en  output  1  one-cycle count-enable pulse to counter
- cnt_up  output  1  direction to counter: 1 = up, 0 = down
- cnt_clr  output  1  one-cycle synchronous clear pulse to counter
- state  output  2  current state: 00 IDLE, 01 RUN, 10 PAUSE, 11 HALT
- done  output  1  high while in HALT

Behaviour:

Reset:
- Sampled on the clk edge when reset==0.
- Reset values: state=IDLE, cnt_en=0, cnt_up=1, cnt_clr=0, done=0, prescaler pcnt=0.
- Reset mid-RUN aborts immediately; no pulse is emitted in the reset cycle.

Outputs:
- All outputs are registered.
- cnt_en and cnt_clr are never high in the same cycle.

Prescaler:
- pcnt has width $clog2(DIV) and counts only in RUN.
- When pcnt==DIV-1: pcnt wraps to 0 and an enable event occurs.
- pcnt is forced to 0 on every entry to RUN, so the first cnt_en is asserted DIV cycles after the entry edge.

Enable event in RUN:
- If (cnt_up && q_in==MAX_VAL) or (!cnt_up && q_in==MIN_VAL): no cnt_en; next state HALT, done=1.
- Otherwise: cnt_en=1 for exactly one cycle.

State transitions:
- IDLE: run_tick -> RUN.
- RUN: run_tick -> PAUSE. pcnt holds its value, but it is re-zeroed on re-entry to RUN.
- PAUSE: run_tick -> RUN.
- HALT: run_tick is ignored; only clr_tick leaves HALT.
- clr_tick in any state:
  - cnt_clr=1 for one cycle.
  - state -> IDLE, done -> 0, pcnt -> 0.
  - cnt_up is unchanged.

Direction:
- dir_tick toggles cnt_up in IDLE, RUN and PAUSE; it is ignored in HALT.
- The new direction applies from the next enable event, and terminal detection uses the updated cnt_up.

Simultaneous ticks (priority):
- clr_tick > run_tick > dir_tick.
- If clr_tick is set, run_tick and dir_tick are ignored that cycle.
- run_tick and dir_tick in the same cycle both take effect.
- A run_tick coinciding with an enable event in RUN: pause wins and no cnt_en is emitted.

Feedback:
- q_in is sampled only at enable events.
- The counter's own value is not modified by this block except via cnt_en and cnt_clr.

Optional Feature:
COUNTER_SEQ_CTRL_AUTORELOAD_EN
- Defined:
  - A terminal condition in RUN issues a cnt_clr pulse instead of entering HALT; state stays RUN, pcnt restarts at 0, and done pulses high for that one cycle.
  - In down mode the clear is still to 0, so down-counting from MIN_VAL=0 reloads to 0 and re-terminates every DIV cycles. Users needing a down reload set MIN_VAL accordingly.
  - HALT is unreachable.
- Undefined: behaviour as specified above (halt at terminal).

Test Plan (DIV=4, MAX_VAL=8'h05, counter model attached):
- Reset then run_tick at cycle 0 -> state=01; cnt_en pulses at cycles 4, 8, 12, …; q_in reaches 5 after 5 pulses; next event -> state=11, done=1, no 6th increment.
- RUN with q_in=2, run_tick -> state=10, no cnt_en while paused; run_tick again -> first cnt_en exactly 4 cycles later.
- In HALT (q_in=5): dir_tick and run_tick ignored; clr_tick -> cnt_clr pulse, state=00, done=0, q_in=0 next cycle.
- RUN up at q_in=3, dir_tick -> following pulses decrement to 0; next event -> HALT (MIN_VAL terminal).
- clr_tick, run_tick and dir_tick asserted in the same cycle from RUN -> only clear: state=00, cnt_up unchanged.
- reset driven low during RUN coinciding with pcnt==DIV-1 -> no cnt_en that cycle, all outputs at reset values; with AUTORELOAD_EN, terminal at q_in=5 -> cnt_clr pulse, done pulse, state stays 01.
